// File: rtl/dense3_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : dense3_argmax
//  Description : Final fully-connected layer with an argmax over its logits.
//                Activations are buffered during LOAD. Each neuron then takes
//                one weight/activation MAC per cycle plus two drain cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module dense3_argmax #(
    parameter int IN_DEPTH  = 84,
    parameter int OUT_DEPTH = 10,
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_wr_en,
    input  logic [31:0] in_wr_addr,
    input  logic [15:0] in_wr_data,
    input  logic        in_done,
    output logic [9:0]  w_addr_out,
    input  logic [15:0] w_data_in,
    output logic [3:0]  b_addr_out,
    input  logic [15:0] b_data_in,
    output logic        logit_wr_en,
    output logic [3:0]  logit_wr_addr,
    output logic [15:0] logit_data,
    output logic [3:0]  class_out,
    output logic        class_valid,
    output logic        busy
);

    localparam int c_cw = $clog2(IN_DEPTH + 2);
    localparam int c_aw = $clog2(IN_DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_mac  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [c_cw-1:0] c_cyc_mac_end = c_cw'(IN_DEPTH);
    localparam logic [c_cw-1:0] c_cyc_last    = c_cw'(IN_DEPTH + 1);
    localparam logic [3:0]      c_neuron_last = 4'(OUT_DEPTH - 1);

    localparam logic signed [31:0] c_sat_hi = 32'sd32767;
    localparam logic signed [31:0] c_sat_lo = -32'sd32768;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [15:0]        r_buf [0:IN_DEPTH-1];
    logic [c_cw-1:0]    r_cyc;
    logic [3:0]         r_neuron;
    logic signed [15:0] r_act;
    logic signed [31:0] r_acc;
    logic signed [15:0] r_best;
    logic [3:0]         r_best_idx;
    logic [3:0]         r_class_out;
    logic               r_class_valid;
    logic               r_logit_wr_en;
    logic [3:0]         r_logit_wr_addr;
    logic [15:0]        r_logit_data;

    logic               w_enter_load;
    logic               w_enter_mac;
    logic signed [15:0] w_wdat;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_acc_sum;
    logic signed [31:0] w_shift;
    logic signed [31:0] w_sum;
    logic signed [15:0] w_result;
    logic [9:0]         w_w_addr;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (en) w_next_state = c_st_load;
            c_st_load: begin
                if (!en)          w_next_state = c_st_idle;
                else if (in_done) w_next_state = c_st_mac;
            end
            c_st_mac: begin
                if (!en)
                    w_next_state = c_st_idle;
                else if (r_neuron == c_neuron_last && r_cyc == c_cyc_last)
                    w_next_state = c_st_done;
            end
            c_st_done: if (!en) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    assign w_enter_load = (r_state == c_st_idle) && en;
    assign w_enter_mac  = (r_state == c_st_load) && (w_next_state == c_st_mac);

    // Activation buffer is not reset; it is cleared on every LOAD entry instead.
    always_ff @(posedge clk) begin
        if (w_enter_load) begin
            for (int i = 0; i < IN_DEPTH; i++) r_buf[i] <= '0;
        end else if (r_state == c_st_load && in_wr_en && in_wr_addr < 32'(IN_DEPTH)) begin
            r_buf[in_wr_addr[c_aw-1:0]] <= in_wr_data;
        end
    end

    // Weight and activation for index i both arrive in cycle i+1.
    assign w_wdat    = w_data_in;
    assign w_prod    = 32'(w_wdat) * 32'(r_act);
    assign w_acc_sum = r_acc + w_prod;
    assign w_shift   = w_acc_sum >>> FRAC_BITS;
    assign w_sum     = w_shift + $signed({{16{b_data_in[15]}}, b_data_in});

    always_comb begin
        w_result = w_sum[15:0];
        if (w_sum > c_sat_hi)      w_result = 16'sh7FFF;
        else if (w_sum < c_sat_lo) w_result = -16'sh8000;
    end

    assign w_w_addr = 10'(r_neuron) * 10'(IN_DEPTH) + 10'(r_cyc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_cyc           <= '0;
            r_neuron        <= '0;
            r_act           <= '0;
            r_acc           <= '0;
            r_best          <= '0;
            r_best_idx      <= '0;
            r_class_out     <= '0;
            r_class_valid   <= 1'b0;
            r_logit_wr_en   <= 1'b0;
            r_logit_wr_addr <= '0;
            r_logit_data    <= '0;
        end else begin
            r_state       <= w_next_state;
            r_logit_wr_en <= 1'b0;
            r_class_valid <= 1'b0;

            if (w_enter_load) r_class_out <= '0;

            if (w_enter_mac) begin
                r_cyc    <= '0;
                r_neuron <= '0;
            end

            if (r_state == c_st_mac) begin
                r_act <= (r_cyc < c_cyc_mac_end) ? r_buf[r_cyc[c_aw-1:0]] : '0;

                if (r_cyc == '0)
                    r_acc <= '0;
                else if (r_cyc <= c_cyc_mac_end)
                    r_acc <= w_acc_sum;

                if (r_cyc == c_cyc_mac_end) begin
                    if (en) begin
                        r_logit_wr_en   <= 1'b1;
                        r_logit_wr_addr <= r_neuron;
                        r_logit_data    <= w_result;
                    end
                    // Strict compare: on a tie the earlier neuron keeps the win.
                    if (r_neuron == '0 || w_result > r_best) begin
                        r_best     <= w_result;
                        r_best_idx <= r_neuron;
                    end
                end

                if (r_cyc == c_cyc_last) begin
                    r_cyc    <= '0;
                    r_neuron <= r_neuron + 4'd1;
                    if (en && r_neuron == c_neuron_last) begin
                        r_class_valid <= 1'b1;
                        r_class_out   <= r_best_idx;
                    end
                end else begin
                    r_cyc <= r_cyc + 1'b1;
                end
            end
        end
    end

    assign w_addr_out    = (r_state == c_st_mac) ? w_w_addr : '0;
    assign b_addr_out    = (r_state == c_st_mac) ? r_neuron : '0;
    assign logit_wr_en   = r_logit_wr_en;
    assign logit_wr_addr = r_logit_wr_addr;
    assign logit_data    = r_logit_data;
    assign class_out     = r_class_out;
    assign class_valid   = r_class_valid;
    assign busy          = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_dense3_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dense3_argmax
//  Description : Scoreboard bench for dense3_argmax with weight/bias ROM models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dense3_argmax;

    localparam int IN_DEPTH  = 84;
    localparam int OUT_DEPTH = 10;
    localparam int FRAC      = 8;
    localparam int NCYC      = IN_DEPTH + 2;
    localparam int WSIZE     = IN_DEPTH * OUT_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_wr_en;
    logic [31:0] in_wr_addr;
    logic [15:0] in_wr_data;
    logic        in_done;
    logic [9:0]  w_addr_out;
    logic [15:0] w_data_in;
    logic [3:0]  b_addr_out;
    logic [15:0] b_data_in;
    logic        logit_wr_en;
    logic [3:0]  logit_wr_addr;
    logic [15:0] logit_data;
    logic [3:0]  class_out;
    logic        class_valid;
    logic        busy;

    dense3_argmax #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .FRAC_BITS(FRAC)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .in_done(in_done),
        .w_addr_out(w_addr_out), .w_data_in(w_data_in),
        .b_addr_out(b_addr_out), .b_data_in(b_data_in),
        .logit_wr_en(logit_wr_en), .logit_wr_addr(logit_wr_addr), .logit_data(logit_data),
        .class_out(class_out), .class_valid(class_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] wrom [0:WSIZE-1];
    logic [15:0] brom [0:15];

    always @(posedge clk) begin
        w_data_in <= (int'(w_addr_out) < WSIZE) ? wrom[w_addr_out] : 16'h0;
        b_data_in <= (int'(b_addr_out) < OUT_DEPTH) ? brom[b_addr_out] : 16'h0;
    end

    typedef struct { int addr; int data; int cyc; } logit_t;
    typedef struct { int cls; int cyc; } cls_t;
    logit_t lq[$];
    cls_t   cq[$];

    int checks = 0;
    int passed = 0;
    int act_m [IN_DEPTH];
    int exp_cls;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin : monitor
        logit_t e;
        cls_t   c;
        if (logit_wr_en) begin
            if (lq.size() == 0) check("unexpected_logit", 1, 0);
            else begin
                e = lq.pop_front();
                check("logit_addr", int'(logit_wr_addr), e.addr);
                check("logit_data", int'($signed(logit_data)), e.data);
                check("logit_cycle", cyc, e.cyc);
            end
        end
        if (class_valid) begin
            if (cq.size() == 0) check("unexpected_class_valid", 1, 0);
            else begin
                c = cq.pop_front();
                check("class_out", int'(class_out), c.cls);
                check("class_cycle", cyc, c.cyc);
            end
        end
    end

    // Reference: straight dot products with 32-bit wrapping, then shift, bias, clamp.
    task automatic push_expect(int mac0, int abort_at);
        int acc, r, best, bidx;
        logit_t e;
        cls_t c;
        best = 0;
        bidx = 0;
        for (int k = 0; k < OUT_DEPTH; k++) begin
            acc = 0;
            for (int i = 0; i < IN_DEPTH; i++)
                acc = acc + int'($signed(wrom[k*IN_DEPTH+i])) * act_m[i];
            r = (acc >>> FRAC) + int'($signed(brom[k]));
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            if (k == 0 || r > best) begin
                best = r;
                bidx = k;
            end
            if (abort_at < 0 || NCYC*k + IN_DEPTH < abort_at) begin
                e.addr = k; e.data = r; e.cyc = mac0 + NCYC*k + NCYC - 1;
                lq.push_back(e);
            end
        end
        exp_cls = bidx;
        if (abort_at < 0) begin
            c.cls = bidx; c.cyc = mac0 + NCYC*OUT_DEPTH;
            cq.push_back(c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int addr, int data);
        in_wr_en   = 1'b1;
        in_wr_addr = 32'(addr);
        in_wr_data = 16'(data);
        if (addr >= 0 && addr < IN_DEPTH) act_m[addr] = data;
        step();
        in_wr_en = 1'b0;
    endtask

    task automatic begin_load();
        for (int i = 0; i < IN_DEPTH; i++) act_m[i] = 0;
        en = 1'b1;
        step();
        check("busy_load", int'(busy), 1);
    endtask

    task automatic finish_run(int abort_at, bit rst_in_done);
        int mac0;
        int n;
        mac0 = cyc + 1;
        in_done = 1'b1;
        push_expect(mac0, abort_at);
        step();
        in_done = 1'b0;
        check("busy_mac", int'(busy), 1);
        if (abort_at >= 0) begin
            while (cyc < mac0 + abort_at) step();
            en = 1'b0;
            step();
            check("busy_after_abort", int'(busy), 0);
            check("w_addr_idle", int'(w_addr_out), 0);
            step();
        end else begin
            n = 0;
            while (!class_valid && n < 1000) begin
                step();
                n++;
            end
            if (n >= 1000) check("class_valid_timeout", 0, 1);
            if (rst_in_done) begin
                rst = 1'b1;
                step();
                check("rst_done_class", int'(class_out), 0);
                check("rst_done_busy", int'(busy), 0);
                rst = 1'b0;
                en  = 1'b0;
                step();
            end else begin
                // DONE must ignore upstream strobes and hold the winner.
                in_done    = 1'b1;
                in_wr_en   = 1'b1;
                in_wr_addr = 32'd0;
                step();
                in_done  = 1'b0;
                in_wr_en = 1'b0;
                check("class_valid_one_cycle", int'(class_valid), 0);
                check("busy_done", int'(busy), 1);
                en = 1'b0;
                step();
                check("busy_idle", int'(busy), 0);
                check("class_held", int'(class_out), exp_cls);
                check("b_addr_idle", int'(b_addr_out), 0);
            end
        end
    endtask

    task automatic rand_rom(int wrange, int brange);
        for (int i = 0; i < WSIZE; i++) wrom[i] = 16'($urandom_range(0, 2*wrange) - wrange);
        for (int i = 0; i < 16; i++)    brom[i] = 16'($urandom_range(0, 2*brange) - brange);
    endtask

    task automatic fill_rom(int wv, int bv);
        for (int i = 0; i < WSIZE; i++) wrom[i] = 16'(wv);
        for (int i = 0; i < 16; i++)    brom[i] = 16'(bv);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_wr_en = 1'b0; in_wr_addr = '0; in_wr_data = '0; in_done = 1'b0;
        fill_rom(0, 0);
        repeat (3) step();
        check("rst_class_out", int'(class_out), 0);
        check("rst_class_valid", int'(class_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_w_addr", int'(w_addr_out), 0);
        check("rst_b_addr", int'(b_addr_out), 0);
        check("rst_logit_wr_en", int'(logit_wr_en), 0);
        rst = 1'b0;
        step();

        // Unit weights and activations; neuron 7 gets a +1.0 bias.
        fill_rom(16'h0100, 0);
        brom[7] = 16'h0100;
        begin_load();
        for (int i = 0; i < IN_DEPTH; i++) wr(i, 16'h0100);
        finish_run(-1, 1'b0);
        check("directed_class7", exp_cls, 7);

        // All-zero weights and biases: every logit ties at 0.
        fill_rom(0, 0);
        begin_load();
        for (int i = 0; i < 20; i++) wr($urandom_range(0, IN_DEPTH-1), $urandom_range(0, 16'h7FFF));
        finish_run(-1, 1'b0);

        // Positive and negative saturation.
        fill_rom(16'h7FFF, 16'h7FFF);
        begin_load();
        wr(0, 16'h7FFF);
        wr(1, 16'h7FFF);
        finish_run(-1, 1'b0);
        fill_rom(16'h8000, 16'h8000);
        begin_load();
        wr(0, 16'h7FFF);
        wr(1, 16'h7FFF);
        finish_run(-1, 1'b0);

        // Out-of-range addresses and a short load.
        rand_rom(512, 4096);
        begin_load();
        wr(84, 16'h1234);
        wr(200, 16'h4321);
        for (int i = 0; i < 10; i++) wr($urandom_range(0, IN_DEPTH-1), $urandom_range(0, 1023));
        finish_run(-1, 1'b0);

        // Random runs including overwrites.
        for (int r = 0; r < 2; r++) begin
            rand_rom(512, 4096);
            begin_load();
            for (int i = 0; i < 40; i++) wr($urandom_range(0, 90), $urandom_range(0, 1023));
            finish_run(-1, 1'b0);
        end

        // Abort mid-MAC, then a clean rerun.
        rand_rom(512, 4096);
        begin_load();
        for (int i = 0; i < 30; i++) wr($urandom_range(0, IN_DEPTH-1), $urandom_range(0, 1023));
        finish_run(300, 1'b0);
        rand_rom(512, 4096);
        begin_load();
        for (int i = 0; i < 30; i++) wr($urandom_range(0, IN_DEPTH-1), $urandom_range(0, 1023));
        finish_run(-1, 1'b0);

        // Reset while in DONE.
        rand_rom(256, 2048);
        begin_load();
        for (int i = 0; i < 30; i++) wr($urandom_range(0, IN_DEPTH-1), $urandom_range(0, 1023));
        finish_run(-1, 1'b1);

        repeat (5) step();
        check("logit_queue_empty", lq.size(), 0);
        check("class_queue_empty", cq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
